// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

   localparam int unsigned XLEN          = 32;
   localparam logic [31:0] INST_END      = 32'h0000_0000;
   localparam int unsigned DEFAULT_DEPTH = 4;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
   } fq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO of fetch entries with synchronous clear.
module sync_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_clear,
   input  logic                     i_push,
   input  fq_entry_t                i_data,
   input  logic                     i_pop,
   output fq_entry_t                o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   fq_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic              push_en, pop_en, empty;

   assign empty   = (count_q == '0);
   assign o_full  = (count_q == CW'(DEPTH));
   assign push_en = i_push && !o_full && !i_clear;
   assign pop_en  = i_pop && !empty && !i_clear;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (i_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Pointer width equals log2(DEPTH), so increments wrap naturally.
         if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
         unique case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push_en) mem_q[wr_ptr_q] <= i_data;
   end

   assign o_data  = mem_q[rd_ptr_q];
   assign o_count = count_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: tags accepted words with a PC, handles start,
// end-of-stream detection and flush redirects around a sync_fifo.
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = DEFAULT_DEPTH,
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_start,
   input  logic                     i_inst_valid,
   input  logic [XLEN-1:0]          i_inst,
   output logic                     o_inst_ready,
   output logic                     o_dec_valid,
   output logic [XLEN-1:0]          o_dec_inst,
   output logic [XLEN-1:0]          o_dec_pc,
   input  logic                     i_dec_ready,
   input  logic                     i_flush,
   input  logic [XLEN-1:0]          i_flush_pc,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_stream_done
);

   logic             start_q, start_d;
   logic             done_q, done_d;
   logic [XLEN-1:0]  wr_pc_q, wr_pc_d;
   logic             full, wr_en, is_end, push, pop;
   fq_entry_t        push_data, head;

   assign o_inst_ready = start_q && !full && !done_q && !i_flush;
   assign wr_en        = i_inst_valid && o_inst_ready;
   assign is_end       = (i_inst == INST_END);
   // The end marker is consumed here and never reaches storage.
   assign push         = wr_en && !is_end;
   assign o_dec_valid  = (o_count != '0);
   assign pop          = o_dec_valid && i_dec_ready && !i_flush;

   assign push_data.inst = i_inst;
   assign push_data.pc   = wr_pc_q;

   always_comb begin
      start_d = start_q | i_start;
      done_d  = done_q;
      wr_pc_d = wr_pc_q;
      if (i_flush) begin
         wr_pc_d = i_flush_pc;
      end else begin
         if (wr_en && is_end) done_d  = 1'b1;
         if (push)            wr_pc_d = wr_pc_q + 32'd4;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         start_q <= 1'b0;
         done_q  <= 1'b0;
         wr_pc_q <= PC_RESET;
      end else begin
         start_q <= start_d;
         done_q  <= done_d;
         wr_pc_q <= wr_pc_d;
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_clear (i_flush),
      .i_push  (push),
      .i_data  (push_data),
      .i_pop   (pop),
      .o_data  (head),
      .o_count (o_count),
      .o_full  (full)
   );

   assign o_dec_inst    = head.inst;
   assign o_dec_pc      = head.pc;
   assign o_stream_done = done_q;

endmodule
